// File: rtl/mem_pkg.sv
// Shared types and sizing for the MEM-stage data responder and its storage array.
package mem_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 11;
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Smallest width (at least 1 bit) that can hold max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((2 ** w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

    // Sized for the largest legal wait-state setting, so any build fits.
    localparam int CNT_W = cnt_width(MAX_WAIT);

endpackage

// File: rtl/sram_array.sv
// Single-port data storage: synchronous write, registered read, no reset on contents.
module sram_array #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int DEPTH  = mem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // One operation per enabled cycle; the read port only moves on a load so
    // the last read word stays visible through the response cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data responder: req/ack handshake with programmable wait states in
// front of a 2K x 16 array, with a stall back to the hazard logic.
//
// state  | meaning
// IDLE   | waiting for req; request registers load on the accept edge
// WAIT   | wait states counting down, array untouched
// ACCESS | array read or write on the latched request
// RESP   | ack pulse, err valid, pipeline released
module data_mem_responder #(
    parameter int ADDR_W      = mem_pkg::ADDR_W,
    parameter int DATA_W      = mem_pkg::DATA_W,
    parameter int DEPTH       = mem_pkg::DEPTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              stall
);

    import mem_pkg::*;

    // With no wait states the accept edge goes straight to the array access.
    localparam state_t FIRST_ST = (WAIT_CYCLES == 0) ? ACCESS : WAIT;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              oor_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_en;
    logic              addr_oor;

    assign addr_oor = |addr[31:ADDR_W];

    // Reset on the same edge as the access must suppress the write, hence rst here.
    assign sram_en = (state == ACCESS) && !oor_q && !rst;

    // Handshake, wait counter and request capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr[ADDR_W-1:0];
                        wdata_q <= wdata;
                        oor_q   <= addr_oor;
                        cnt     <= CNT_W'(WAIT_CYCLES);
                        state   <= FIRST_ST;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                end
                RESP: begin
                    // Whatever was presented in the ack cycle is held until the next ack.
                    rdata_q <= rdata;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Load data is live from the array only in the ack cycle; stores keep the old word.
    always_comb begin
        rdata = rdata_q;
        if (state == RESP) begin
            if (oor_q) begin
                rdata = '0;
            end else if (!we_q) begin
                rdata = sram_rdata;
            end
        end
    end

    assign ack   = (state == RESP);
    assign err   = (state == RESP) && oor_q;
    assign stall = ((state == IDLE) && req) || (state == WAIT) || (state == ACCESS);

    sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder, with a behavioural
// memory model; a second instance covers the zero-wait-state build.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req,  we;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack, err, stall;
    logic        req0, we0;
    logic [31:0] addr0;
    logic [15:0] wdata0;
    logic [15:0] rdata0;
    logic        ack0, err0, stall0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [longint];
    logic [15:0] held [2];
    logic [31:0] pool [6];

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .stall(stall)
    );

    data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .err(err0), .stall(stall0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit z, input bit r, input bit w, input logic [31:0] a, input logic [15:0] d);
        if (z) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req = r; we = w; addr = a; wdata = d;
        end
    endtask

    // Called at a negedge. b2b: req already high from the previous ack cycle.
    task automatic do_txn(input bit z, input bit w, input logic [31:0] a, input logic [15:0] d,
                          input bit b2b, input bit hold, output logic [15:0] rd, output logic er);
        int k;
        int lat;
        lat = (z ? 2 : 4) + (b2b ? 1 : 0);
        drive(z, 1'b1, w, a, d);
        if (!b2b) begin
            #1 check("stall_on_req", z ? stall0 : stall, 1);
        end
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if ((z ? ack0 : ack) === 1'b1) break;
            check("stall_busy", z ? stall0 : stall, 1);
            if (k == (b2b ? 2 : 1)) begin
                drive(z, 1'b1, ~w, $urandom, 16'($urandom));
            end
        end
        check("ack_latency", k, lat);
        check("stall_in_ack", z ? stall0 : stall, 0);
        rd = z ? rdata0 : rdata;
        er = z ? err0 : err;
        if (!hold) begin
            drive(z, 1'b0, 1'b0, 32'h0, 16'h0);
            @(negedge clk);
            check("ack_one_cycle", z ? ack0 : ack, 0);
            check("stall_idle", z ? stall0 : stall, 0);
        end
    endtask

    // Transaction plus model prediction of rdata/err.
    task automatic txn(input bit z, input bit w, input logic [31:0] a, input logic [15:0] d,
                       input bit b2b, input bit hold);
        logic [15:0] rd;
        logic        er;
        logic [15:0] exp_rd;
        logic        exp_er;
        longint      key;
        key = longint'(a) + (z ? 64'h1_0000_0000 : 64'h0);
        do_txn(z, w, a, d, b2b, hold, rd, er);
        if (a > 32'd2047) begin
            exp_rd = 16'h0;
            exp_er = 1'b1;
        end else if (w) begin
            mdl[key] = d;
            exp_rd = held[z];
            exp_er = 1'b0;
        end else begin
            exp_rd = mdl.exists(key) ? mdl[key] : 16'h0;
            exp_er = 1'b0;
        end
        held[z] = exp_rd;
        check(w ? "store_rdata" : "load_rdata", rd, exp_rd);
        check("err", er, exp_er);
        if (!hold) begin
            check("rdata_held", z ? rdata0 : rdata, held[z]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        held[0] = 16'h0;
        held[1] = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_ack", ack, 0);
            check("rst_stall", stall, 0);
            check("rst_rdata", rdata, 0);
            check("rst_err", err, 0);
        end

        txn(0, 1, 32'h10, 16'hBEEF, 0, 0);
        txn(0, 0, 32'h10, 16'h0, 0, 0);
        txn(0, 0, 32'h800, 16'h0, 0, 0);
        txn(0, 0, 32'h10, 16'h0, 0, 0);

        for (int i = 1; i <= 3; i++) txn(0, 1, i, 16'(i), 0, 0);
        txn(0, 0, 32'h1, 16'h0, 0, 1);
        txn(0, 0, 32'h2, 16'h0, 1, 1);
        txn(0, 0, 32'h3, 16'h0, 1, 0);

        txn(0, 1, 32'h5, 16'hAAAA, 0, 0);
        drive(0, 1, 1, 32'h5, 16'h1234);
        @(negedge clk);
        check("abort_stall", stall, 1);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        held[0] = 16'h0;
        held[1] = 16'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_ack", ack, 0);
        end
        check("abort_rdata", rdata, 0);
        txn(0, 0, 32'h5, 16'h0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            pool[i] = 32'($urandom_range(0, 2047));
            txn(0, 1, pool[i], 16'($urandom), 0, 0);
        end
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom;
                if (a[31:11] == 21'h0) a[31] = 1'b1;
            end else begin
                a = pool[$urandom_range(0, 5)];
            end
            txn(0, 1'($urandom_range(0, 1)), a, 16'($urandom), 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        txn(1, 1, 32'h9, 16'h0077, 0, 0);
        txn(1, 0, 32'h9, 16'h0, 0, 0);
        txn(1, 0, 32'h1000, 16'h0, 0, 0);
        txn(1, 1, 32'h9, 16'h5A5A, 0, 1);
        txn(1, 0, 32'h9, 16'h0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
